cpu_jtag_debug_dispatch: RTL and testbench

Parametrised JTAG-to-CPU debug command dispatcher for the Nios-class debug subsystem. Accepts a data word and instruction code shifted in by the JTAG-domain shifter, announced by an asynchronous update toggle. Brings the command into the CPU clock domain, latches it onto `jdo`, and fires one-cycle `take_action`/`take_no_action` strobes per instruction channel toward the OCI, break, trace and memory units. Generalises the fixed 38-bit, fixed-strobe debug module to arbitrary data width and channel count, adding a return acknowledge, overrun detection, and synchronised JTAG reset/idle status.

---
 rtl/cpu_jtag_debug_dispatch_if.sv | 33 +++
 rtl/cpu_jtag_debug_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_jtag_debug_dispatch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_jtag_debug_dispatch_if.sv
// ----------------------------------------------------------------------------
// cpu_jtag_debug_dispatch_if
// Command handshake between the JTAG-domain shifter and the CPU-domain debug
// dispatcher.
//   jtag_sr            : shifted command data (JTAG side drives)
//   jtag_ir            : instruction code / channel select (JTAG side drives)
//   jtag_update_toggle : each transition announces one command (JTAG side)
//   jtag_ack_toggle    : toggles once per consumed command (dispatcher drives)
// Modports: master = JTAG shifter side, slave = dispatcher side.
// ----------------------------------------------------------------------------
interface cpu_jtag_debug_dispatch_if #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2
);
    logic [DATA_W-1:0] jtag_sr;
    logic [IR_W-1:0]   jtag_ir;
    logic              jtag_update_toggle;
    logic              jtag_ack_toggle;

    modport master (
        output jtag_sr,
        output jtag_ir,
        output jtag_update_toggle,
        input  jtag_ack_toggle
    );

    modport slave (
        input  jtag_sr,
        input  jtag_ir,
        input  jtag_update_toggle,
        output jtag_ack_toggle
    );
endinterface

// File: rtl/cpu_jtag_debug_dispatch.sv
// ----------------------------------------------------------------------------
// cpu_jtag_debug_dispatch
// Brings a JTAG-shifted debug command into the CPU clock domain, latches it on
// jdo and fires a one-cycle take_action / take_no_action strobe on the channel
// selected by the instruction code. Also synchronises the TAP idle status and
// the JTAG-side reset, and flags commands that arrive while one is in flight.
//
// Ports:
//   clk, reset_n        : CPU clock, asynchronous active-low reset
//   jtag (slave)        : jtag_sr / jtag_ir / jtag_update_toggle in,
//                         jtag_ack_toggle out
//   jtag_rti            : async TAP Run-Test/Idle indication
//   jtag_rst_n          : async JTAG-side reset, active-low
//   overrun_clr         : synchronous clear of overrun
//   jdo                 : latched command data
//   take_action         : one-cycle strobe per channel, jdo[ACTION_BIT]=1
//   take_no_action      : one-cycle strobe per channel, jdo[ACTION_BIT]=0
//   st_ready_test_idle  : synchronised jtag_rti
//   jrst_n              : reset-synchronised jtag_rst_n
//   overrun             : sticky, update arrived while busy
//   parity_err          : sticky, odd-parity failure (parity build only)
//
// Optional feature macro: JTAG_DISPATCH_PARITY_EN -- when defined, the top bit
// of jtag_sr carries odd parity over the remaining bits; a failing command is
// acknowledged but produces no strobe.
// ----------------------------------------------------------------------------
module cpu_jtag_debug_dispatch #(
    parameter  int DATA_W      = 38,
    parameter  int IR_W        = 2,
    parameter  int ACTION_BIT  = 35,
    parameter  int SYNC_STAGES = 2,
    localparam int NCH         = 2**IR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_jtag_debug_dispatch_if.slave jtag,
    input  logic                  jtag_rti,
    input  logic                  jtag_rst_n,
    input  logic                  overrun_clr,
    output logic [DATA_W-1:0]     jdo,
    output logic [NCH-1:0]        take_action,
    output logic [NCH-1:0]        take_no_action,
    output logic                  st_ready_test_idle,
    output logic                  jrst_n,
    output logic                  overrun
`ifdef JTAG_DISPATCH_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

`ifdef JTAG_DISPATCH_PARITY_EN
    // Odd parity: the whole word, parity bit included, has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] upd_sync_r;
    logic                   upd_hist_r;
    logic                   upd_edge_s;
    logic [SYNC_STAGES-1:0] rti_sync_r;
    logic [SYNC_STAGES-1:0] jrst_sync_r;
    logic                   jrst_arst_n_s;
    logic [DATA_W-1:0]      jdo_r;
    logic [NCH-1:0]         take_action_r;
    logic [NCH-1:0]         take_no_action_r;
    logic                   ack_r;
    logic                   overrun_r;
    logic [NCH-1:0]         chan_onehot_s;
    logic                   cmd_ok_s;
`ifdef JTAG_DISPATCH_PARITY_EN
    logic                   parity_err_r;
`endif

    // Update-toggle synchroniser plus history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_sync_r <= '0;
            upd_hist_r <= 1'b0;
        end else begin
            upd_sync_r <= {upd_sync_r[SYNC_STAGES-2:0], jtag.jtag_update_toggle};
            upd_hist_r <= upd_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detect, channel decode and command validity (parity build only).
    always_comb begin
        upd_edge_s    = upd_sync_r[SYNC_STAGES-1] ^ upd_hist_r;
        chan_onehot_s = NCH'(1) << jtag.jtag_ir;
`ifdef JTAG_DISPATCH_PARITY_EN
        cmd_ok_s      = odd_parity_ok(jtag.jtag_sr);
`else
        cmd_ok_s      = 1'b1;
`endif
    end

    // Command FSM. Strobes are decoded while in CAPTURE so that they become
    // visible together with the freshly latched jdo on entry to ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            jdo_r            <= '0;
            take_action_r    <= '0;
            take_no_action_r <= '0;
            ack_r            <= 1'b0;
`ifdef JTAG_DISPATCH_PARITY_EN
            parity_err_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    take_action_r    <= '0;
                    take_no_action_r <= '0;
                    if (upd_edge_s) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    jdo_r <= jtag.jtag_sr;
                    if (cmd_ok_s) begin
                        if (jtag.jtag_sr[ACTION_BIT]) begin
                            take_action_r    <= chan_onehot_s;
                            take_no_action_r <= '0;
                        end else begin
                            take_action_r    <= '0;
                            take_no_action_r <= chan_onehot_s;
                        end
                    end else begin
                        take_action_r    <= '0;
                        take_no_action_r <= '0;
`ifdef JTAG_DISPATCH_PARITY_EN
                        parity_err_r     <= 1'b1;
`endif
                    end
                    state_r <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    take_action_r    <= '0;
                    take_no_action_r <= '0;
                    ack_r            <= ~ack_r;
                    state_r          <= ST_IDLE;
                end
                default: begin
                    take_action_r    <= '0;
                    take_no_action_r <= '0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: an edge seen while busy is dropped; set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (upd_edge_s && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Plain synchroniser for the TAP Run-Test/Idle status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rti_sync_r <= '0;
        end else begin
            rti_sync_r <= {rti_sync_r[SYNC_STAGES-2:0], jtag_rti};
        end
    end

    // Either reset source asserts jrst_n immediately; release is synchronous.
    assign jrst_arst_n_s = reset_n & jtag_rst_n;

    // Reset synchroniser for the JTAG-side reset.
    always_ff @(posedge clk or negedge jrst_arst_n_s) begin
        if (!jrst_arst_n_s) begin
            jrst_sync_r <= '0;
        end else begin
            jrst_sync_r <= {jrst_sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign jdo                  = jdo_r;
    assign take_action          = take_action_r;
    assign take_no_action       = take_no_action_r;
    assign jtag.jtag_ack_toggle = ack_r;
    assign st_ready_test_idle   = rti_sync_r[SYNC_STAGES-1];
    assign jrst_n               = jrst_sync_r[SYNC_STAGES-1];
    assign overrun              = overrun_r;
`ifdef JTAG_DISPATCH_PARITY_EN
    assign parity_err           = parity_err_r;
`endif

endmodule

// File: tb/tb_cpu_jtag_debug_dispatch.sv
// ----------------------------------------------------------------------------
// tb_cpu_jtag_debug_dispatch
// Scoreboard bench: each issued command pushes its expected strobe/jdo and
// sample cycle into a queue; a monitor pops and compares on every strobe.
// Status outputs (ack, overrun, jrst_n, st_ready_test_idle) are checked
// directly by the stimulus process against hand-computed values.
// ----------------------------------------------------------------------------
module tb_cpu_jtag_debug_dispatch;

    localparam int DATA_W = 38;
    localparam int IR_W   = 2;
    localparam int NCH    = 4;

    typedef struct {
        logic [DATA_W-1:0] jdo;
        logic [NCH-1:0]    ta;
        logic [NCH-1:0]    tna;
        int                cyc;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic              jtag_rti;
    logic              jtag_rst_n;
    logic              overrun_clr;
    logic [DATA_W-1:0] jdo;
    logic [NCH-1:0]    take_action;
    logic [NCH-1:0]    take_no_action;
    logic              st_ready_test_idle;
    logic              jrst_n;
    logic              overrun;
`ifdef JTAG_DISPATCH_PARITY_EN
    logic              parity_err;
    logic              exp_perr;
`endif

    int   checks;
    int   errors;
    int   cyc;
    int   last_t0;
    logic exp_ack;
    exp_t exp_q[$];

    cpu_jtag_debug_dispatch_if #(.DATA_W(DATA_W), .IR_W(IR_W)) jif ();

    cpu_jtag_debug_dispatch #(
        .DATA_W(DATA_W), .IR_W(IR_W), .ACTION_BIT(35), .SYNC_STAGES(2)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .jtag               (jif.slave),
        .jtag_rti           (jtag_rti),
        .jtag_rst_n         (jtag_rst_n),
        .overrun_clr        (overrun_clr),
        .jdo                (jdo),
        .take_action        (take_action),
        .take_no_action     (take_no_action),
        .st_ready_test_idle (st_ready_test_idle),
        .jrst_n             (jrst_n),
        .overrun            (overrun)
`ifdef JTAG_DISPATCH_PARITY_EN
        ,
        .parity_err         (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count active edges so latencies can be checked in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected command.
    always @(negedge clk) begin
        if ((take_action | take_no_action) != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: ta=%b tna=%b jdo=%h, required no strobe",
                         take_action, take_no_action, jdo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (take_action !== e.ta || take_no_action !== e.tna ||
                    jdo !== e.jdo || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe: ta=%b tna=%b jdo=%h cyc=%0d, required ta=%b tna=%b jdo=%h cyc=%0d",
                             take_action, take_no_action, jdo, cyc, e.ta, e.tna, e.jdo, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Present a command and flip the update toggle; called at a falling edge.
    task automatic issue(input logic [DATA_W-1:0] sr, input logic [IR_W-1:0] ir,
                         input logic [NCH-1:0] ta, input logic [NCH-1:0] tna);
        exp_t e;
        bit   strobe_expected;
        strobe_expected = 1'b1;
`ifdef JTAG_DISPATCH_PARITY_EN
        if (^sr == 1'b0) begin
            strobe_expected = 1'b0;
            exp_perr        = 1'b1;
        end
`endif
        jif.jtag_sr            = sr;
        jif.jtag_ir            = ir;
        jif.jtag_update_toggle = ~jif.jtag_update_toggle;
        last_t0                = cyc;
        exp_ack                = ~exp_ack;
        if (strobe_expected) begin
            e.jdo = sr;
            e.ta  = ta;
            e.tna = tna;
            e.cyc = last_t0 + 4;
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for the ack to toggle and check its latency.
    task automatic wait_ack(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (jif.jtag_ack_toggle == exp_ack) break;
        end
        check({name, "_ack"}, {63'd0, jif.jtag_ack_toggle}, {63'd0, exp_ack});
        check({name, "_ack_cyc"}, 64'(cyc), 64'(last_t0 + 5));
    endtask

    task automatic send(input string name, input logic [DATA_W-1:0] sr,
                        input logic [IR_W-1:0] ir,
                        input logic [NCH-1:0] ta, input logic [NCH-1:0] tna);
        issue(sr, ir, ta, tna);
        wait_ack(name);
        repeat (2) @(negedge clk);
        check({name, "_jdo_hold"}, 64'(jdo), 64'(sr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        exp_ack = 1'b0;
`ifdef JTAG_DISPATCH_PARITY_EN
        exp_perr = 1'b0;
`endif
        reset_n                = 1'b0;
        jtag_rti               = 1'b0;
        jtag_rst_n             = 1'b1;
        overrun_clr            = 1'b0;
        jif.jtag_sr            = '0;
        jif.jtag_ir            = '0;
        jif.jtag_update_toggle = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_jdo",     64'(jdo), 64'd0);
        check("rst_strobes", 64'({take_action, take_no_action}), 64'd0);
        check("rst_ack",     {63'd0, jif.jtag_ack_toggle}, 64'd0);
        check("rst_rti",     {63'd0, st_ready_test_idle}, 64'd0);
        check("rst_jrst_n",  {63'd0, jrst_n}, 64'd0);
        check("rst_overrun", {63'd0, overrun}, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("jrst_n_after_reset", {63'd0, jrst_n}, 64'd1);

        // Directed commands: action on ch2, no-action on ch0, ch3, ch1.
        send("cmd_act_ch2",  38'h08_0000_1234, 2'd2, 4'b0100, 4'b0000);
`ifdef JTAG_DISPATCH_PARITY_EN
        check("parity_err_set", {63'd0, parity_err}, {63'd0, exp_perr});
`endif
        send("cmd_noact_ch0", 38'h00_0000_1234, 2'd0, 4'b0000, 4'b0001);
        send("cmd_act_ch3",   38'h08_ABCD_0001, 2'd3, 4'b1000, 4'b0000);
        send("cmd_noact_ch1", 38'h37_FFFF_FFFF, 2'd1, 4'b0000, 4'b0010);

        // Overrun: second toggle two cycles after the first is dropped.
        issue(38'h08_0000_0005, 2'd1, 4'b0010, 4'b0000);
        repeat (2) @(negedge clk);
        jif.jtag_update_toggle = ~jif.jtag_update_toggle;
        wait_ack("ovr");
        repeat (4) @(negedge clk);
        check("ovr_set",      {63'd0, overrun}, 64'd1);
        check("ovr_no_2nd_ack", {63'd0, jif.jtag_ack_toggle}, {63'd0, exp_ack});
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", {63'd0, overrun}, 64'd0);

        // JTAG-side reset: immediate assert, release after two edges.
        jtag_rst_n = 1'b0;
        #1;
        check("jrst_assert", {63'd0, jrst_n}, 64'd0);
        @(negedge clk);
        jtag_rst_n = 1'b1;
        @(posedge clk); #1;
        check("jrst_edge1", {63'd0, jrst_n}, 64'd0);
        @(posedge clk); #1;
        check("jrst_edge2", {63'd0, jrst_n}, 64'd1);

        // Run-Test/Idle synchroniser latency.
        @(negedge clk);
        jtag_rti = 1'b1;
        @(posedge clk); #1;
        check("rti_edge1", {63'd0, st_ready_test_idle}, 64'd0);
        @(posedge clk); #1;
        check("rti_edge2", {63'd0, st_ready_test_idle}, 64'd1);

        // Reset during CAPTURE drops the command; JTAG side resets its toggle.
        @(negedge clk);
        jif.jtag_sr            = 38'h08_5555_0000;
        jif.jtag_ir            = 2'd3;
        jif.jtag_update_toggle = ~jif.jtag_update_toggle;
        repeat (3) @(negedge clk);
        reset_n                = 1'b0;
        jif.jtag_update_toggle = 1'b0;
        exp_ack                = 1'b0;
`ifdef JTAG_DISPATCH_PARITY_EN
        exp_perr               = 1'b0;
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_ack", {63'd0, jif.jtag_ack_toggle}, 64'd0);
        check("midrst_jdo", 64'(jdo), 64'd0);

        // Recovery after reset.
        send("cmd_after_rst", 38'h28_0000_1234, 2'd2, 4'b0100, 4'b0000);
`ifdef JTAG_DISPATCH_PARITY_EN
        check("parity_err_final", {63'd0, parity_err}, {63'd0, exp_perr});
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
